// File: rtl/led_share_arbiter_if.sv
// LED-share bus: four requesters' request/pattern lines plus the arbiter's
// grant, LED drive and prescaler tick.
interface led_share_arbiter_if;
  logic [3:0] req;
  logic [7:0] pat0;
  logic [7:0] pat1;
  logic [7:0] pat2;
  logic [7:0] pat3;
  logic [3:0] grant;
  logic [7:0] led;
  logic       tick;

  modport master (
    output req, pat0, pat1, pat2, pat3,
    input  grant, led, tick
  );

  modport slave (
    input  req, pat0, pat1, pat2, pat3,
    output grant, led, tick
  );
endinterface

// File: rtl/led_share_arbiter.sv
// Time-sliced round-robin arbiter sharing 8 LEDs among four pattern requesters,
// with a 1 s prescaler, idle heartbeat and minimum-hold rotation.
module led_share_arbiter #(
  parameter logic [26:0] TICK_DIV   = 27'd124999999,
  parameter logic [7:0]  HOLD_TICKS = 8'd2
) (
  input  logic               clk,
  input  logic               rst,
  led_share_arbiter_if.slave arb
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t      r_state, w_state_nxt;
  logic [26:0] r_cnt;
  logic        r_tick;
  logic        r_hb;
  logic [3:0]  r_grant, w_grant_nxt;
  logic [1:0]  r_owner, w_owner_nxt;
  logic [7:0]  r_hold, w_hold_nxt;
  logic [1:0]  r_rr_ptr, w_rr_nxt;
  logic [7:0]  r_led, w_led_nxt;

  logic        w_wrap;
  logic        w_found;
  logic [1:0]  w_winner;
  logic [1:0]  w_idx;
  logic [7:0]  w_pat_owner;
  logic        w_release;
  logic [7:0]  w_hold_inc;

  assign w_wrap = (r_cnt == TICK_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_hb   <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 27'd1;
      r_tick <= w_wrap;
      if (w_wrap) r_hb <= ~r_hb;
    end
  end

  // Search starts just past the previous owner, so it is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && arb.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    case (r_owner)
      2'd0:    w_pat_owner = arb.pat0;
      2'd1:    w_pat_owner = arb.pat1;
      2'd2:    w_pat_owner = arb.pat2;
      default: w_pat_owner = arb.pat3;
    endcase
  end

  assign w_release  = !arb.req[r_owner] ||
                      ((r_hold == HOLD_TICKS) && ((arb.req & ~r_grant) != 4'b0000));
  assign w_hold_inc = (r_hold < HOLD_TICKS) ? r_hold + 8'd1 : HOLD_TICKS;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_rr_nxt    = r_rr_ptr;
    w_led_nxt   = r_led;
    case (r_state)
      S_IDLE: begin
        w_led_nxt = {8{r_hb}};
        if (w_found) begin
          w_grant_nxt = 4'b0001 << w_winner;
          w_owner_nxt = w_winner;
          w_hold_nxt  = '0;
          w_state_nxt = S_OWN;
        end
      end
      S_OWN: begin
        w_led_nxt = w_pat_owner;
        if (w_release) begin
          w_grant_nxt = '0;
          w_rr_nxt    = r_owner;
          w_state_nxt = S_IDLE;
        end else if (r_tick) begin
          w_hold_nxt = w_hold_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_hold   <= '0;
      r_rr_ptr <= 2'd3;
      r_led    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_hold   <= w_hold_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_led    <= w_led_nxt;
    end
  end

  assign arb.grant = r_grant;
  assign arb.led   = r_led;
  assign arb.tick  = r_tick;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter: vector table for heartbeat and single
// owner, hand sequences for rotation, round-robin order, reset and HOLD_TICKS=0.
module tb_led_share_arbiter;

  logic clk;
  logic rst;

  led_share_arbiter_if a_if ();
  led_share_arbiter_if b_if ();

  led_share_arbiter #(.TICK_DIV(27'd9), .HOLD_TICKS(8'd2)) u_dut (
    .clk (clk),
    .rst (rst),
    .arb (a_if)
  );

  led_share_arbiter #(.TICK_DIV(27'd9), .HOLD_TICKS(8'd0)) u_dut_h0 (
    .clk (clk),
    .rst (rst),
    .arb (b_if)
  );

  typedef struct {
    int         at;
    logic [3:0] exp_grant;
    logic [7:0] exp_led;
    logic       exp_tick;
    logic [3:0] req;
    logic [7:0] pat0;
  } vec_t;

  vec_t tbl [0:14];

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int onehot_bad = 0;
  int sole_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if ($countones(a_if.grant) > 1 || $countones(b_if.grant) > 1) onehot_bad++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int exp_h0 [1:6];

    rst       = 1'b1;
    a_if.req  = '0; a_if.pat0 = '0; a_if.pat1 = '0; a_if.pat2 = '0; a_if.pat3 = '0;
    b_if.req  = '0; b_if.pat0 = '0; b_if.pat1 = '0; b_if.pat2 = '0; b_if.pat3 = '0;

    // at, grant, led, tick | inputs applied after the check: req, pat0
    tbl[0]  = '{0,  4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
    tbl[1]  = '{9,  4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
    tbl[2]  = '{10, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00};
    tbl[3]  = '{11, 4'h0, 8'hFF, 1'b0, 4'h0, 8'h00};
    tbl[4]  = '{20, 4'h0, 8'hFF, 1'b1, 4'h0, 8'h00};
    tbl[5]  = '{21, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00};
    tbl[6]  = '{30, 4'h0, 8'h00, 1'b1, 4'h0, 8'h00};
    tbl[7]  = '{31, 4'h0, 8'hFF, 1'b0, 4'h1, 8'hA5};
    tbl[8]  = '{32, 4'h1, 8'hFF, 1'b0, 4'h1, 8'hA5};
    tbl[9]  = '{33, 4'h1, 8'hA5, 1'b0, 4'h1, 8'h3C};
    tbl[10] = '{34, 4'h1, 8'h3C, 1'b0, 4'h0, 8'h3C};
    tbl[11] = '{35, 4'h0, 8'h3C, 1'b0, 4'h0, 8'h3C};
    tbl[12] = '{36, 4'h0, 8'hFF, 1'b0, 4'h0, 8'h3C};
    tbl[13] = '{40, 4'h0, 8'hFF, 1'b1, 4'h0, 8'h3C};
    tbl[14] = '{41, 4'h0, 8'h00, 1'b0, 4'h0, 8'h3C};

    // Heartbeat and single-owner vectors
    do_reset();
    for (int i = 0; i < 15; i++) begin
      goto(tbl[i].at);
      chk($sformatf("vec%0d grant", i), 32'(a_if.grant), 32'(tbl[i].exp_grant));
      chk($sformatf("vec%0d led", i),   32'(a_if.led),   32'(tbl[i].exp_led));
      chk($sformatf("vec%0d tick", i),  32'(a_if.tick),  32'(tbl[i].exp_tick));
      a_if.req  = tbl[i].req;
      a_if.pat0 = tbl[i].pat0;
    end

    // Two-way rotation with HOLD_TICKS=2
    a_if.req = '0;
    do_reset();
    a_if.req = 4'b0101; a_if.pat0 = 8'h11; a_if.pat2 = 8'h22;
    goto(1);  chk("rot first grant", 32'(a_if.grant), 32'h1);
    goto(2);  chk("rot led p0", 32'(a_if.led), 32'h11);
    goto(21); chk("rot hold0", 32'(a_if.grant), 32'h1);
    goto(22); chk("rot gap1", 32'(a_if.grant), 32'h0);
    goto(23); chk("rot grant2", 32'(a_if.grant), 32'h4);
    goto(24); chk("rot led p2", 32'(a_if.led), 32'h22);
    goto(41); chk("rot hold2", 32'(a_if.grant), 32'h4);
    goto(42); chk("rot gap2", 32'(a_if.grant), 32'h0);
    goto(43); chk("rot back0", 32'(a_if.grant), 32'h1);
    goto(63); chk("rot again2", 32'(a_if.grant), 32'h4);

    // Reset while owner 2 holds the LEDs, on the edge that would have ticked
    goto(69); chk("pre-rst led", 32'(a_if.led), 32'h22);
    rst = 1'b1;
    step();
    chk("rst grant", 32'(a_if.grant), 32'h0);
    chk("rst led",   32'(a_if.led),   32'h00);
    chk("rst tick",  32'(a_if.tick),  32'h0);
    rst = 1'b0;
    cyc = 0;
    goto(1);  chk("post-rst grant", 32'(a_if.grant), 32'h1);
    goto(9);  chk("post-rst tick9", 32'(a_if.tick), 32'h0);
    goto(10); chk("post-rst tick10", 32'(a_if.tick), 32'h1);

    // Round-robin order: owner 2 releases with 1011 pending
    a_if.req = '0;
    do_reset();
    a_if.req = 4'b0100;
    goto(1);  chk("rr owner2", 32'(a_if.grant), 32'h4);
    goto(5);  a_if.req = 4'b1011;
    goto(6);  chk("rr gap", 32'(a_if.grant), 32'h0);
    goto(7);  chk("rr next3", 32'(a_if.grant), 32'h8);
    goto(22); chk("rr gap3", 32'(a_if.grant), 32'h0);
    goto(23); chk("rr next0", 32'(a_if.grant), 32'h1);
    goto(43); chk("rr next1", 32'(a_if.grant), 32'h2);

    // Sole requester on main DUT; two contenders on the HOLD_TICKS=0 DUT
    a_if.req = '0;
    do_reset();
    a_if.req = 4'b0010; a_if.pat1 = 8'hC3;
    b_if.req = 4'b0011;
    exp_h0 = '{1, 0, 2, 0, 1, 0};
    for (int c = 1; c <= 6; c++) begin
      goto(c);
      chk($sformatf("h0 grant c%0d", c), 32'(b_if.grant), 32'(exp_h0[c]));
    end
    while (cyc < 501) begin
      step();
      if (a_if.grant !== 4'b0010) sole_bad++;
    end
    chk("sole no gap", 32'(sole_bad), 32'h0);
    chk("sole led", 32'(a_if.led), 32'hC3);
    chk("onehot grant", 32'(onehot_bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
